// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: state encoding, opcode/funct
// values, ALU operation codes and datapath mux-select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EXEC,
        S_ADDI_WB
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_RS     = 1'b1;
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decode into the 4-bit ALU operation code, with a
// valid flag that is low for any funct outside the supported set.
module alu_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       valid
);

    always_comb begin
        alu_ctl = ALU_ADD;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_NOR:  alu_ctl = ALU_NOR;
            default: valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable, Moore-decoded from the state.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [3:0]  alu_ctl,
    output logic        illegal_op
);

    state_e     state_q, state_d;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] funct_alu;
    logic       funct_valid;
    logic       instr_unused;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign instr_unused = ^instr[25:6];

    alu_funct_decode u_funct_dec (
        .funct   (funct),
        .alu_ctl (funct_alu),
        .valid   (funct_valid)
    );

    // Async reset drops straight into RST, so an in-flight write strobe dies at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        i_or_d     = IORD_PC;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RT;
        pc_source  = PCSRC_ALU;
        alu_ctl    = ALU_AND;
        illegal_op = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctl   = ALU_ADD;
                // IR load and PC+4 commit only once the instruction word has arrived.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_ctl   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_d = S_R_EXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                alu_ctl   = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = IORD_ALUOUT;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = IORD_ALUOUT;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = SRCA_RS;
                alu_ctl   = funct_alu;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS;
                alu_ctl   = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                alu_ctl   = ALU_ADD;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: each instruction is expanded into its per-cycle control vectors,
// queued, and compared against the controller outputs by an independent monitor.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_ctl;
        logic       illegal_op;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_source;
    logic [3:0]  alu_ctl;
    ctl_t        act;

    ctl_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle_n = 0;
    logic [31:0] cur_instr = 32'h0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_ctl    (alu_ctl),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_n <= cycle_n + 1;

    assign act = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_ctl, illegal_op};

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            ctl_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl cycle=%0d instr=%h: got %b required %b",
                         cycle_n, instr, act, e);
            end
        end
    end

    // Expected control vectors, written from the datapath role of each step.
    function automatic ctl_t ex_fetch(input logic r);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctl = 4'b0010;
        c.ir_write = r;    c.pc_write = r;
        return c;
    endfunction

    function automatic ctl_t ex_decode(input logic ill);
        ctl_t c = '0;
        c.alu_src_b = 2'b11; c.alu_ctl = 4'b0010; c.illegal_op = ill;
        return c;
    endfunction

    function automatic ctl_t ex_rs_imm_add();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = 4'b0010;
        return c;
    endfunction

    function automatic ctl_t ex_mem(input logic wr);
        ctl_t c = '0;
        c.i_or_d = 1'b1; c.mem_read = !wr; c.mem_write = wr;
        return c;
    endfunction

    function automatic ctl_t ex_wb(input logic dst, input logic m2r);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
        return c;
    endfunction

    function automatic ctl_t ex_rexec(input logic [3:0] code);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_ctl = code;
        return c;
    endfunction

    function automatic ctl_t ex_branch(input logic z);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_ctl = 4'b0110; c.pc_source = 2'b01; c.pc_write = z;
        return c;
    endfunction

    function automatic ctl_t ex_jump();
        ctl_t c = '0;
        c.pc_source = 2'b10; c.pc_write = 1'b1;
        return c;
    endfunction

    function automatic logic model_funct(input logic [5:0] f, output logic [3:0] code);
        code = 4'b0000;
        case (f)
            6'b100000: code = 4'b0010;
            6'b100010: code = 4'b0110;
            6'b100100: code = 4'b0000;
            6'b100101: code = 4'b0001;
            6'b100111: code = 4'b1100;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input logic mr, input logic z, input ctl_t e);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        instr     = cur_instr;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: outputs %b required all zero", name, act);
        end
    endtask

    task automatic do_fetch(input int fwait);
        repeat (fwait) cyc(1'b0, rbit(), ex_fetch(1'b0));
        cyc(1'b1, rbit(), ex_fetch(1'b1));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fwait, input int mwait);
        logic [31:0] r;
        logic [3:0]  code;
        logic        fok;
        r  = $urandom();
        fok = model_funct(fn, code);
        do_fetch(fwait);
        cur_instr = {op, r[25:6], fn};
        case (op)
            6'b100011: begin
                cyc(rbit(), rbit(), ex_decode(1'b0));
                cyc(rbit(), rbit(), ex_rs_imm_add());
                repeat (mwait) cyc(1'b0, rbit(), ex_mem(1'b0));
                cyc(1'b1, rbit(), ex_mem(1'b0));
                cyc(rbit(), rbit(), ex_wb(1'b0, 1'b1));
            end
            6'b101011: begin
                cyc(rbit(), rbit(), ex_decode(1'b0));
                cyc(rbit(), rbit(), ex_rs_imm_add());
                repeat (mwait) cyc(1'b0, rbit(), ex_mem(1'b1));
                cyc(1'b1, rbit(), ex_mem(1'b1));
            end
            6'b000000: begin
                cyc(rbit(), rbit(), ex_decode(!fok));
                if (fok) begin
                    cyc(rbit(), rbit(), ex_rexec(code));
                    cyc(rbit(), rbit(), ex_wb(1'b1, 1'b0));
                end
            end
            6'b000100: begin
                cyc(rbit(), rbit(), ex_decode(1'b0));
                cyc(rbit(), z, ex_branch(z));
            end
            6'b000010: begin
                cyc(rbit(), rbit(), ex_decode(1'b0));
                cyc(rbit(), rbit(), ex_jump());
            end
            6'b001000: begin
                cyc(rbit(), rbit(), ex_decode(1'b0));
                cyc(rbit(), rbit(), ex_rs_imm_add());
                cyc(rbit(), rbit(), ex_wb(1'b0, 1'b0));
            end
            default: cyc(rbit(), rbit(), ex_decode(1'b1));
        endcase
    endtask

    // Reset pulled mid-way through an R-type execute cycle, then released.
    task automatic reset_mid_rexec();
        do_fetch(0);
        cur_instr = {6'b000000, 20'h12345, 6'b100010};
        cyc(1'b1, 1'b0, ex_decode(1'b0));
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_rexec");
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b001000};
    logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100,
                                  6'b100101, 6'b100111};

    initial begin
        #2;
        check_zero("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);

        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        reset_mid_rexec();
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b100000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);
        run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 1, 3);

        for (int i = 0; i < 200; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom())
                                             : legal_ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom())
                                             : legal_fns[$urandom_range(0, 4)];
            run_instr(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main controller for the MIPS-subset datapath. It sequences instruction fetch, decode, execute, memory and write-back over several cycles and drives every datapath mux select and write enable. It also drives the 4-bit ALU operation code directly, using the same code set as the existing ALU control (add 0010, sub 0110, and 0000, or 0001, nor 1100). It sits between the instruction register / memory interface and the register file / ALU / PC.

## Interface
- No parameters. Opcode, funct, ALU-code and state constants come from the shared package.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  current IR contents; stable from DECODE until the next FETCH completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC load enable; already includes the branch condition.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory request strobes.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  register write address: 0 = rt, 1 = rd.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_ctl  out  4  ALU operation code.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- Supported opcodes (instr[31:26]): R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Supported funct values (instr[5:0]): 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor.
- All outputs are Moore-decoded from state. The only exceptions are in FETCH and the memory states, where some outputs are qualified by mem_ready (noted below).
- Any output not listed for a state is 0.
- States and transitions:
  - RST: all outputs 0. Next state FETCH.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=0010, pc_source=00. ir_write and pc_write are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=0010 (branch target into ALUOut). Next state by opcode:
    - lw or sw → MEM_ADDR
    - R-type with a supported funct → R_EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDI_EXEC
    - anything else → FETCH, with illegal_op=1.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctl=0010. Next state MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctl from the funct decode. Next state R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctl=0110, pc_source=01, pc_write=zero. Next state FETCH.
  - JUMP: pc_source=10, pc_write=1. Next state FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_ctl=0010. Next state ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Unsupported funct in DECODE (with R-type opcode): illegal_op=1, next state FETCH, no register write.
- mem_write and reg_write are never asserted in the same cycle. mem_read and mem_write are never asserted together.

## Timing
- Reset: rst_n low forces state RST asynchronously, so all outputs are 0 immediately. The first FETCH begins on the first rising edge after rst_n is released.
- Reset asserted in any state, including during a held MEM_WRITE: no further write strobe is issued and no pending write is retried.
- Cycle counts with mem_ready tied high:
  - lw: 5 cycles (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB).
  - sw: 4 cycles.
  - R-type and addi: 4 cycles.
  - beq and j: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- illegal_op is high only during the single DECODE cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit),
  - opcode and funct localparams,
  - ALU code localparams (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_NOR=1100),
  - the mux-select encodings.
- Sub-module alu_funct_decode: combinational, funct → {alu_ctl, valid}. Instantiated once; its valid output is used in DECODE.

## Test plan
- Reset and fetch: assert rst_n low mid-R_EXEC → all outputs 0 immediately. Release → FETCH on the next edge with mem_read=1 and alu_src_b=01.
- R-type sub (funct 100010), mem_ready=1: R_EXEC drives alu_ctl=0110 and alu_src_b=00; R_WB drives reg_write=1, reg_dst=1; back in FETCH after 4 cycles total.
- lw with mem_ready low for 2 cycles in MEM_READ: 7-cycle instruction; mem_to_reg=1 and reg_write=1 asserted exactly once.
- beq: zero=1 → pc_write=1 with pc_source=01 in BRANCH. zero=0 → pc_write=0. Both cases return to FETCH.
- sw: mem_write=1 with i_or_d=1 for exactly one cycle; reg_write is never asserted.
- Illegal input: opcode 111111, then R-type with funct 000111 → illegal_op pulses once in each DECODE cycle, no writes occur, and FETCH follows immediately.
